// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory access controller: RV32I funct3 encodings,
// FSM state codes and the default acknowledge timeout.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam int unsigned TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, alignment/legality checks, store lane
// shifting and load byte/halfword selection with sign or zero extension.
module lsu_align
    import dmem_pkg::*;
(
    input  logic        rd,
    input  logic        wr,
    input  logic [2:0]  fun_3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] write_data,
    input  logic [2:0]  ld_fun_3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] mem_rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic        misaligned,
    output logic        illegal,
    output logic [31:0] load_data
);

    logic [4:0]  st_shamt;
    logic [31:0] ld_shifted;

    assign st_shamt   = {addr_lo, 3'b000};
    assign ld_shifted = mem_rdata >> {ld_off, 3'b000};

    always_comb begin
        illegal = 1'b0;
        if (rd && wr) begin
            illegal = 1'b1;
        end else if (rd) begin
            illegal = !(fun_3 == F3_B || fun_3 == F3_H || fun_3 == F3_W ||
                        fun_3 == F3_BU || fun_3 == F3_HU);
        end else if (wr) begin
            illegal = !(fun_3 == F3_B || fun_3 == F3_H || fun_3 == F3_W);
        end
    end

    // Size lives in fun_3[1:0]; bit 2 only selects zero extension for loads.
    always_comb begin
        be         = 4'b0000;
        wdata      = 32'h0;
        misaligned = 1'b0;
        unique case (fun_3[1:0])
            2'b00: begin
                be    = 4'b0001 << addr_lo;
                wdata = {24'h0, write_data[7:0]} << st_shamt;
            end
            2'b01: begin
                be         = 4'b0011 << addr_lo;
                wdata      = {16'h0, write_data[15:0]} << st_shamt;
                misaligned = addr_lo[0];
            end
            2'b10: begin
                be         = 4'b1111;
                wdata      = write_data;
                misaligned = (addr_lo != 2'b00);
            end
            default: begin
                be = 4'b0000;
            end
        endcase
    end

    always_comb begin
        load_data = 32'h0;
        case (ld_fun_3)
            F3_B:    load_data = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
            F3_H:    load_data = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
            F3_W:    load_data = mem_rdata;
            F3_BU:   load_data = {24'h0, ld_shifted[7:0]};
            F3_HU:   load_data = {16'h0, ld_shifted[15:0]};
            default: load_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Turns one pipeline load/store into one word-aligned backend transaction and
// stalls the pipeline until it acknowledges, errors out or times out.
module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
    parameter int unsigned ADDR_W  = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              d_mem_r,
    input  logic              d_mem_w,
    input  logic [2:0]        fun_3,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       write_data,
    output logic [31:0]       read_data,
    output logic              busy_wait,
    output logic              acc_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [1:0]       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       ld_fun_3_q;
    logic [1:0]       ld_off_q;

    logic        req, err_req, timed_out;
    logic        misaligned, illegal;
    logic [3:0]  be;
    logic [31:0] wdata, load_data;

    lsu_align u_lsu_align (
        .rd         (d_mem_r),
        .wr         (d_mem_w),
        .fun_3      (fun_3),
        .addr_lo    (address[1:0]),
        .write_data (write_data),
        .ld_fun_3   (ld_fun_3_q),
        .ld_off     (ld_off_q),
        .mem_rdata  (mem_rdata),
        .be         (be),
        .wdata      (wdata),
        .misaligned (misaligned),
        .illegal    (illegal),
        .load_data  (load_data)
    );

    assign req       = d_mem_r | d_mem_w;
    assign err_req   = req & (misaligned | illegal);
    assign timed_out = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        busy_wait = 1'b0;
        case (state_q)
            IDLE:    busy_wait = req & ~err_req;
            WAIT:    busy_wait = 1'b1;
            default: busy_wait = 1'b0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ld_fun_3_q <= 3'b000;
            ld_off_q   <= 2'b00;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= 32'h0;
            mem_be     <= 4'b0000;
            read_data  <= 32'h0;
            acc_err    <= 1'b0;
        end else begin
            acc_err <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (err_req) begin
                        acc_err   <= 1'b1;
                        read_data <= 32'h0;
                    end else if (req) begin
                        mem_req    <= 1'b1;
                        mem_we     <= d_mem_w;
                        mem_addr   <= address[ADDR_W-1:2];
                        mem_be     <= be;
                        mem_wdata  <= wdata;
                        ld_fun_3_q <= fun_3;
                        ld_off_q   <= address[1:0];
                        cnt_q      <= '0;
                        state_q    <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_ack) begin
                        if (!mem_we) begin
                            read_data <= load_data;
                        end
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        state_q <= RESP;
                    end else if (timed_out) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        acc_err   <= 1'b1;
                        read_data <= 32'h0;
                        state_q   <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Responder for the data-memory request signals the decode/control stage produces: d_mem_r and d_mem_w, with fun_3 giving the access size.
- Sits between the EX/MEM pipeline stage and the data cache or main memory port.
- Turns one pipeline load or store into one word-aligned backend transaction, using byte enables and load extension.
- Stalls the pipeline with busy_wait until the transaction completes, errors out, or times out.

Parameters:
- TIMEOUT, 255: maximum number of cycles to wait for mem_ack before aborting; 0 disables the timeout.
- ADDR_W, 32: width of the pipeline address.

Ports:
- CLK  input  1  rising-edge clock
- RESET  input  1  reset, synchronous, active-low
- d_mem_r  input  1  load request from the pipeline
- d_mem_w  input  1  store request from the pipeline
- fun_3  input  3  access size and signedness (RV32I load/store funct3)
- address  input  ADDR_W  byte address, taken from the ALU result
- write_data  input  32  store data, in rs2 form
- read_data  output  32  extended load result
- busy_wait  output  1  pipeline stall request
- acc_err  output  1  one-cycle pulse: misaligned access, illegal access or timeout
- mem_req  output  1  backend request, held high until acknowledged
- mem_we  output  1  backend write strobe
- mem_addr  output  ADDR_W-2  backend word address
- mem_wdata  output  32  lane-shifted store data
- mem_be  output  4  byte enables
- mem_rdata  input  32  backend read word
- mem_ack  input  1  backend completion, a one-cycle pulse

Behaviour:
- Reset state: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0, read_data=0, acc_err=0, timeout counter=0.
- FSM states:
  - IDLE: when a request is present, busy_wait=1 combinationally in the same cycle. At the clock edge, register mem_req=1, mem_we, mem_addr=address[ADDR_W-1:2], mem_be and mem_wdata, then go to WAIT.
  - WAIT: busy_wait=1 and mem_req is held.
    - On mem_ack, capture the extended load result into read_data (stores leave read_data unchanged), drop mem_req and mem_we, and go to RESP.
    - If the counter reaches TIMEOUT first, drop mem_req, pulse acc_err, set read_data=0 and go to RESP.
  - RESP: busy_wait=0 so the pipeline advances. Always return to IDLE; a new request is not accepted in RESP.
- Latency: minimum 3 cycles (IDLE, WAIT, RESP). busy_wait is high for 1+N cycles, where N is the number of WAIT cycles.
- Access sizes:
  - Loads: 000 LB and 100 LBU (any address), 001 LH and 101 LHU (address[0]=0), 010 LW (address[1:0]=0).
  - Stores: 000 SB, 001 SH, 010 SW, with the same alignment rules as loads.
- Byte enables: SB gives 0001<<address[1:0]; SH gives 0011<<address[1:0]; SW gives 1111.
- Store data: placed on the addressed lane(s) of mem_wdata; unused lanes are 0.
- Load extension: select the addressed byte or halfword; sign-extend for 000/001, zero-extend for 100/101.
- Error cases: misaligned access, illegal fun_3, or d_mem_r and d_mem_w both high. In IDLE these cause:
  - no backend access and busy_wait=0;
  - acc_err pulse on the next cycle;
  - read_data=0 on the next cycle;
  - state stays IDLE.
- Timeout counter: cleared on entry to WAIT and increments each WAIT cycle.
- mem_ack outside WAIT is ignored, including a late ack after a timeout or after reset.
- Reset asserted mid-WAIT: next edge returns to IDLE with all outputs at their reset values; the pending transaction is abandoned.
- Address wrap: mem_addr uses address bits ADDR_W-1:2 only; there is no carry or overflow handling.

Decomposition:
- dmem_pkg holds:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - the state enum {IDLE, WAIT, RESP};
  - the TIMEOUT default.
- Sub-module lsu_align: purely combinational. Computes mem_be, the misaligned/illegal flags, lane-shifted store data and the extended load result. The FSM stays in dmem_access_ctrl.

Test Plan:
- LW at 0x100; backend returns mem_rdata=0xDEADBEEF with ack on the first WAIT cycle. Expect mem_addr=0x40, mem_be=1111, busy_wait high 2 cycles, read_data=0xDEADBEEF in RESP.
- LB at 0x103 and LBU at 0x103, with mem_rdata=0x80FF_0000. Expect read_data=0xFFFFFF80 for LB and 0x00000080 for LBU.
- SH at 0x202 with write_data=0x1234ABCD. Expect mem_we=1, mem_be=1100, mem_wdata=0xABCD0000.
- LH at 0x101, then d_mem_r and d_mem_w both high. Each gives no mem_req, busy_wait=0 and an acc_err pulse.
- TIMEOUT=4 with mem_ack never asserted. Expect mem_req to drop after 4 WAIT cycles, an acc_err pulse, read_data=0, and a late ack ignored.
- RESET low during WAIT. Expect IDLE with all outputs at reset values on the next edge; a following LW completes normally.
